field_dispatch_fsm: RTL and testbench
=====================================

FIELD_DISPATCH_FSM -- requirements
Module: field_dispatch_fsm

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 16, legal 1..31: max dispatched-but-unretired field indices.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_fifo_empty  input  1  parsed-field FIFO empty.
REQ-005 in_wire_type  input  3  protobuf wire type of FIFO head entry, valid when in_fifo_empty=0.
REQ-006 in_fifo_pop  output  1  one-cycle pop of FIFO head.
REQ-007 varint_fifo_full  input  1  varint decoder input FIFO full.
REQ-008 varint_push  output  1  push field into varint decoder.
REQ-009 varint_index_d  output  10  output-order index tagged on varint push.
REQ-010 raw_data_fifo_full  input  1  raw-data unit input FIFO full.
REQ-011 raw_data_push  output  1  push field into raw-data unit.
REQ-012 raw_data_index_d  output  10  output-order index tagged on raw-data push.
REQ-013 index_retire  input  1  one-cycle pulse: output merger completed one index.
REQ-014 flush  input  1  one-cycle pulse: drain then reinitialise.
REQ-015 outstanding  output  5  dispatched minus retired count.
REQ-016 bad_count  output  8  illegal wire types discarded, saturating.
REQ-017 underflow_err  output  1  sticky: retire seen with outstanding=0.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 States (one-hot): INIT, IDLE, V_DISP, R_DISP, BAD, FLUSH; unknown encoding -> INIT.
REQ-020 Class: wire type 0 = varint; 1, 2, 5 = raw; 3, 4, 6, 7 = illegal.
REQ-021 INIT: next_index<=0, outstanding<=0, no pushes/pops; -> IDLE next cycle.
REQ-022 IDLE priority: flush -> FLUSH; else in_fifo_empty -> IDLE; else illegal -> BAD; else outstanding=MAX_OUTSTANDING -> IDLE; else varint & ~varint_fifo_full -> V_DISP; raw & ~raw_data_fifo_full -> R_DISP; else IDLE.
REQ-023 V_DISP: in_fifo_pop=1, varint_push=1, varint_index_d=next_index for exactly that cycle; next_index increments; outstanding +1; -> IDLE.
REQ-024 R_DISP: identical to V_DISP on raw_data_push/raw_data_index_d; -> IDLE.
REQ-025 Index rule: next_index 10-bit, 1023 -> 0 wrap; indices strictly sequential across both targets.
REQ-026 BAD: in_fifo_pop=1, no push, no index consumed, bad_count +1 saturating at 255; -> IDLE.
REQ-027 Dispatch latency: head visible in IDLE -> push in following cycle; max one dispatch per 2 cycles.
REQ-028 Index outputs hold last pushed value when push=0.
REQ-029 Retire: outstanding -1 per pulse in any state; same-cycle dispatch and retire leaves it unchanged.
REQ-030 Retire at outstanding=0 with no same-cycle dispatch: ignored, underflow_err<=1 until reset.
REQ-031 flush outside IDLE is latched and acted on at next IDLE entry.
REQ-032 FLUSH: no pops/pushes; stay while outstanding!=0; -> INIT when outstanding=0.
REQ-033 Target-full or credit-exhausted: stay in IDLE, no pop, head held.

Reset
REQ-034 reset: state=INIT, next_index=0, outstanding=0, bad_count=0, underflow_err=0, flush latch=0, all push/pop=0, index outputs=0; overrides any state mid-operation, no partial push.

Verification
REQ-035 Types 0,2,0,5 queued, targets free -> pushes V idx0, R idx1, V idx2, R idx3 on cycles 2,4,6,8 after IDLE entry; outstanding=4.
REQ-036 MAX_OUTSTANDING=4, 6 varints, no retire -> 4 pushes then stall; one retire -> 5th push idx4 two cycles later.
REQ-037 1030 raw fields with retire each push -> index 1023 followed by 0; outstanding never above 1.
REQ-038 Type 3 at head -> pop, no push, bad_count=1, next field gets unconsumed index; 300 illegal -> bad_count=255.
REQ-039 flush with outstanding=3 -> no dispatch until 3 retires, then INIT, next push idx0.
REQ-040 Retire at outstanding=0 -> underflow_err=1, outstanding stays 0; reset mid-V_DISP-cycle -> all outputs at REQ-034 values next cycle.

Source files
------------

// File: rtl/field_dispatch_fsm_if.sv
// -----------------------------------------------------------------------------
// field_dispatch_fsm_if
//
// Purpose: bundles every handshake, status and control signal of the field
// dispatcher so that it is passed around as one port. The dispatcher uses the
// master view. The surrounding pipeline (parsed-field FIFO, varint decoder,
// raw-data unit, output merger) uses the slave view.
//
// Signals
//   in_fifo_empty       parsed-field FIFO is empty
//   in_wire_type[2:0]   protobuf wire type of the FIFO head entry
//   in_fifo_pop         one-cycle pop of the FIFO head
//   varint_fifo_full    varint decoder input FIFO is full
//   varint_push         push the head field into the varint decoder
//   varint_index_d      output-order index tagged on a varint push
//   raw_data_fifo_full  raw-data unit input FIFO is full
//   raw_data_push       push the head field into the raw-data unit
//   raw_data_index_d    output-order index tagged on a raw-data push
//   index_retire        one-cycle pulse: the merger completed one index
//   flush               one-cycle pulse: drain, then reinitialise
//   outstanding[4:0]    dispatched-but-unretired index count
//   bad_count[7:0]      illegal wire types discarded (saturating)
//   underflow_err       sticky: a retire arrived with nothing outstanding
//   busy                dispatcher is anywhere but IDLE
// -----------------------------------------------------------------------------
interface field_dispatch_fsm_if;
  logic       in_fifo_empty;
  logic [2:0] in_wire_type;
  logic       in_fifo_pop;
  logic       varint_fifo_full;
  logic       varint_push;
  logic [9:0] varint_index_d;
  logic       raw_data_fifo_full;
  logic       raw_data_push;
  logic [9:0] raw_data_index_d;
  logic       index_retire;
  logic       flush;
  logic [4:0] outstanding;
  logic [7:0] bad_count;
  logic       underflow_err;
  logic       busy;

  // Dispatcher side.
  modport master (
    input  in_fifo_empty,
    input  in_wire_type,
    input  varint_fifo_full,
    input  raw_data_fifo_full,
    input  index_retire,
    input  flush,
    output in_fifo_pop,
    output varint_push,
    output varint_index_d,
    output raw_data_push,
    output raw_data_index_d,
    output outstanding,
    output bad_count,
    output underflow_err,
    output busy
  );

  // Surrounding pipeline side.
  modport slave (
    output in_fifo_empty,
    output in_wire_type,
    output varint_fifo_full,
    output raw_data_fifo_full,
    output index_retire,
    output flush,
    input  in_fifo_pop,
    input  varint_push,
    input  varint_index_d,
    input  raw_data_push,
    input  raw_data_index_d,
    input  outstanding,
    input  bad_count,
    input  underflow_err,
    input  busy
  );
endinterface

// File: rtl/field_dispatch_fsm.sv
// -----------------------------------------------------------------------------
// field_dispatch_fsm
//
// Purpose: takes parsed protobuf fields from the head of a FIFO and routes
// each one by wire type. Varints go to the varint decoder. Length-delimited,
// fixed32 and fixed64 fields go to the raw-data unit. Illegal wire types are
// popped and counted. Every dispatched field is tagged with a strictly
// sequential 10-bit output-order index that is shared by both targets. The
// number of dispatched-but-unretired indices is capped at MAX_OUTSTANDING so
// that the output merger cannot be overrun.
//
// Parameters
//   MAX_OUTSTANDING  credit limit, legal range 1..31 (default 16)
//
// Ports
//   clk    rising-edge clock for all state
//   reset  synchronous active-high reset
//   bus    field_dispatch_fsm_if.master (signal list in the interface file)
//
// Timing: a head entry seen in IDLE is pushed in the next cycle. The FSM then
// returns to IDLE, so it dispatches at most one field every two cycles.
// -----------------------------------------------------------------------------
module field_dispatch_fsm #(
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  field_dispatch_fsm_if.master bus
);

  typedef enum logic [5:0] {
    ST_INIT   = 6'b000001,
    ST_IDLE   = 6'b000010,
    ST_V_DISP = 6'b000100,
    ST_R_DISP = 6'b001000,
    ST_BAD    = 6'b010000,
    ST_FLUSH  = 6'b100000
  } state_t;

  localparam logic [4:0] MAX_OUT = 5'(MAX_OUTSTANDING);

  state_t     state_reg;
  state_t     state_next;
  logic [9:0] next_index_reg;
  logic [9:0] varint_index_reg;
  logic [9:0] raw_index_reg;
  logic [4:0] outstanding_reg;
  logic [7:0] bad_count_reg;
  logic       underflow_reg;
  logic       flush_pend_reg;

  logic       pop_next;
  logic       varint_push_next;
  logic       raw_push_next;

  // ---------------------------------------------------------------------------
  // Wire-type classification. These are small constant lookup vectors indexed
  // by the 3-bit wire type. Type 0 is a varint. Types 1, 2 and 5 are raw data.
  // Everything else is illegal.
  // ---------------------------------------------------------------------------
  logic [7:0] varint_lut;
  logic [7:0] raw_lut;

  for (genvar gi = 0; gi < 8; gi++) begin : g_class
    assign varint_lut[gi] = (gi == 0);
    assign raw_lut[gi]    = (gi == 1) || (gi == 2) || (gi == 5);
  end

  logic head_varint;
  logic head_raw;
  logic head_illegal;

  assign head_varint  = varint_lut[bus.in_wire_type];
  assign head_raw     = raw_lut[bus.in_wire_type];
  assign head_illegal = ~(head_varint | head_raw);

  // A flush pulse seen in IDLE is acted on at once. One seen in any other
  // state waits in flush_pend_reg until the FSM is back in IDLE.
  logic flush_req;
  logic credit_out;
  logic dispatch;

  assign flush_req  = bus.flush | flush_pend_reg;
  assign credit_out = (outstanding_reg >= MAX_OUT);
  assign dispatch   = varint_push_next | raw_push_next;

  // ---------------------------------------------------------------------------
  // Next state and per-state strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = ST_INIT;
    pop_next         = 1'b0;
    varint_push_next = 1'b0;
    raw_push_next    = 1'b0;

    case (state_reg)
      ST_INIT: begin
        state_next = ST_IDLE;
      end

      ST_IDLE: begin
        // Illegal heads are discarded even when credits are exhausted, so a
        // bad entry can never block the FIFO behind a stalled merger.
        if (flush_req) begin
          state_next = ST_FLUSH;
        end else if (bus.in_fifo_empty) begin
          state_next = ST_IDLE;
        end else if (head_illegal) begin
          state_next = ST_BAD;
        end else if (credit_out) begin
          state_next = ST_IDLE;
        end else if (head_varint && !bus.varint_fifo_full) begin
          state_next = ST_V_DISP;
        end else if (head_raw && !bus.raw_data_fifo_full) begin
          state_next = ST_R_DISP;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_V_DISP: begin
        state_next       = ST_IDLE;
        pop_next         = 1'b1;
        varint_push_next = 1'b1;
      end

      ST_R_DISP: begin
        state_next    = ST_IDLE;
        pop_next      = 1'b1;
        raw_push_next = 1'b1;
      end

      ST_BAD: begin
        state_next = ST_IDLE;
        pop_next   = 1'b1;
      end

      ST_FLUSH: begin
        // Hold here until the merger has retired everything in flight. INIT
        // then restarts the index sequence from zero.
        if (outstanding_reg == 5'd0) begin
          state_next = ST_INIT;
        end else begin
          state_next = ST_FLUSH;
        end
      end

      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Index allocation. The tag outputs are loaded on the IDLE->DISP transition.
  // As a result they already show next_index during the push cycle and then
  // hold that value until the next push to the same target.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      next_index_reg <= 10'd0;
    end else if (state_reg == ST_INIT) begin
      next_index_reg <= 10'd0;
    end else if (dispatch) begin
      next_index_reg <= next_index_reg + 10'd1;  // 1023 wraps to 0
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      varint_index_reg <= 10'd0;
      raw_index_reg    <= 10'd0;
    end else if (state_reg == ST_IDLE) begin
      if (state_next == ST_V_DISP) begin
        varint_index_reg <= next_index_reg;
      end
      if (state_next == ST_R_DISP) begin
        raw_index_reg <= next_index_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Credit tracking. A dispatch and a retire in the same cycle cancel out. A
  // retire with nothing outstanding and no dispatch to cover it is dropped and
  // raises the sticky underflow flag.
  // ---------------------------------------------------------------------------
  logic retire_underflow;

  assign retire_underflow = bus.index_retire && !dispatch && (outstanding_reg == 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_reg <= 5'd0;
    end else if (state_reg == ST_INIT) begin
      outstanding_reg <= 5'd0;
    end else if (dispatch && !bus.index_retire) begin
      outstanding_reg <= outstanding_reg + 5'd1;
    end else if (!dispatch && bus.index_retire && (outstanding_reg != 5'd0)) begin
      outstanding_reg <= outstanding_reg - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      underflow_reg <= 1'b0;
    end else if (retire_underflow) begin
      underflow_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Illegal-entry counter, saturating at 255
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      bad_count_reg <= 8'd0;
    end else if ((state_reg == ST_BAD) && (bad_count_reg != 8'hFF)) begin
      bad_count_reg <= bad_count_reg + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Deferred flush. Leaving IDLE is the point where any pending request is
  // consumed: either it just sent the FSM to FLUSH, or nothing was pending.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_pend_reg <= 1'b0;
    end else if (state_reg == ST_IDLE) begin
      flush_pend_reg <= 1'b0;
    end else if (bus.flush) begin
      flush_pend_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_fifo_pop      = pop_next;
  assign bus.varint_push      = varint_push_next;
  assign bus.raw_data_push    = raw_push_next;
  assign bus.varint_index_d   = varint_index_reg;
  assign bus.raw_data_index_d = raw_index_reg;
  assign bus.outstanding      = outstanding_reg;
  assign bus.bad_count        = bad_count_reg;
  assign bus.underflow_err    = underflow_reg;
  assign bus.busy             = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_field_dispatch_fsm.sv
// -----------------------------------------------------------------------------
// tb_field_dispatch_fsm
//
// Bench for field_dispatch_fsm with MAX_OUTSTANDING = 4. A queue stands in for
// the parsed-field FIFO. A transaction-level model follows index allocation,
// credits, illegal counting and underflow, and it is compared every cycle. A
// table of single-entry vectors covers wire-type classification and
// target-full holding. Hand-written sequences cover the multi-cycle cases.
// -----------------------------------------------------------------------------
module tb_field_dispatch_fsm;

  localparam int MAXO = 4;

  logic clk;
  logic reset;

  field_dispatch_fsm_if bus_if();

  field_dispatch_fsm #(
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit raw;
    int idx;
  } plog_t;

  typedef struct {
    logic [2:0] wt;
    bit         vfull;
    bit         rfull;
    int         exp_pop;
    int         exp_v;
    int         exp_r;
    int         exp_bad;
  } vec_t;

  int         errors;
  int         checks;
  int         cycle;
  int         pop_cnt;
  int         exp_out;
  int         exp_bad;
  int         exp_idx;
  int         last_v;
  int         last_r;
  bit         exp_uf;
  bit         push_s;
  bit         busy_s;
  bit         reset_on_push;
  logic [2:0] fq[$];
  plog_t      plog[$];
  vec_t       vecs[13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic int cls(input logic [2:0] wt);
    case (wt)
      3'd0:             return 1;
      3'd1, 3'd2, 3'd5: return 2;
      default:          return 0;
    endcase
  endfunction

  task automatic drive();
    bus_if.in_fifo_empty = (fq.size() == 0);
    bus_if.in_wire_type  = (fq.size() == 0) ? 3'd0 : fq[0];
  endtask

  // One clock cycle: check and sample at the negedge, then advance the FIFO
  // model just after the posedge.
  task automatic step();
    logic pop_s;
    logic vp;
    logic rp;
    int   c;
    bit   disp_e;
    @(negedge clk);
    cycle++;
    pop_s  = bus_if.in_fifo_pop;
    vp     = bus_if.varint_push;
    rp     = bus_if.raw_data_push;
    busy_s = bus_if.busy;
    push_s = vp | rp;
    if (!reset) begin
      check("outstanding", int'(bus_if.outstanding), exp_out);
      check("bad_count", int'(bus_if.bad_count), exp_bad);
      check("underflow_err", int'(bus_if.underflow_err), int'(exp_uf));
      c = (fq.size() > 0) ? cls(fq[0]) : -1;
      if (fq.size() == 0) check("pop_on_empty", int'(pop_s), 0);
      check("varint_push", int'(vp), int'(pop_s && c == 1));
      check("raw_push", int'(rp), int'(pop_s && c == 2));
      if (vp) begin
        check("varint_idx", int'(bus_if.varint_index_d), exp_idx);
        last_v  = exp_idx;
        exp_idx = (exp_idx + 1) % 1024;
      end else begin
        check("varint_idx_hold", int'(bus_if.varint_index_d), last_v);
      end
      if (rp) begin
        check("raw_idx", int'(bus_if.raw_data_index_d), exp_idx);
        last_r  = exp_idx;
        exp_idx = (exp_idx + 1) % 1024;
      end else begin
        check("raw_idx_hold", int'(bus_if.raw_data_index_d), last_r);
      end
      if (vp || rp) plog.push_back('{cycle, bit'(rp), rp ? int'(bus_if.raw_data_index_d) : int'(bus_if.varint_index_d)});
      if (pop_s) pop_cnt++;
      disp_e = pop_s && (c == 1 || c == 2);
      if (disp_e && !bus_if.index_retire) exp_out++;
      else if (!disp_e && bus_if.index_retire) begin
        if (exp_out == 0) exp_uf = 1'b1;
        else exp_out--;
      end
      if (pop_s && c == 0 && exp_bad < 255) exp_bad++;
    end
    if (reset_on_push && (vp || rp)) begin
      reset = 1'b1;
      reset_on_push = 1'b0;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      exp_out = 0;
      exp_bad = 0;
      exp_idx = 0;
      exp_uf  = 1'b0;
      last_v  = 0;
      last_r  = 0;
      fq.delete();
    end else if (pop_s && fq.size() > 0) begin
      void'(fq.pop_front());
    end
    bus_if.index_retire = 1'b0;
    bus_if.flush        = 1'b0;
    drive();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pop"}, int'(bus_if.in_fifo_pop), 0);
    check({tag, "_vpush"}, int'(bus_if.varint_push), 0);
    check({tag, "_rpush"}, int'(bus_if.raw_data_push), 0);
    check({tag, "_vidx"}, int'(bus_if.varint_index_d), 0);
    check({tag, "_ridx"}, int'(bus_if.raw_data_index_d), 0);
    check({tag, "_outstanding"}, int'(bus_if.outstanding), 0);
    check({tag, "_bad"}, int'(bus_if.bad_count), 0);
    check({tag, "_underflow"}, int'(bus_if.underflow_err), 0);
    check({tag, "_busy"}, int'(bus_if.busy), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fq.delete();
    drive();
    step();
    step();
    check_reset_vals("reset");
    reset  = 1'b0;
    push_s = 1'b0;
    plog.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_c;
    int n0;
    int nv;
    int nr;
    int pops0;
    int bad0;
    int guard;
    int max_o;
    errors = 0;
    checks = 0;
    cycle = 0;
    pop_cnt = 0;
    exp_out = 0;
    exp_bad = 0;
    exp_idx = 0;
    exp_uf = 1'b0;
    last_v = 0;
    last_r = 0;
    reset_on_push = 1'b0;
    reset = 1'b1;
    bus_if.varint_fifo_full   = 1'b0;
    bus_if.raw_data_fifo_full = 1'b0;
    bus_if.index_retire       = 1'b0;
    bus_if.flush              = 1'b0;
    drive();

    //                wt   vf rf pop v  r  bad
    vecs[0]  = '{3'd0, 0, 0, 1, 1, 0, 0};
    vecs[1]  = '{3'd1, 0, 0, 1, 0, 1, 0};
    vecs[2]  = '{3'd2, 0, 0, 1, 0, 1, 0};
    vecs[3]  = '{3'd5, 0, 0, 1, 0, 1, 0};
    vecs[4]  = '{3'd3, 0, 0, 1, 0, 0, 1};
    vecs[5]  = '{3'd4, 0, 0, 1, 0, 0, 1};
    vecs[6]  = '{3'd6, 0, 0, 1, 0, 0, 1};
    vecs[7]  = '{3'd7, 0, 0, 1, 0, 0, 1};
    vecs[8]  = '{3'd0, 1, 0, 0, 0, 0, 0};
    vecs[9]  = '{3'd2, 0, 1, 0, 0, 0, 0};
    vecs[10] = '{3'd0, 0, 1, 1, 1, 0, 0};
    vecs[11] = '{3'd5, 1, 0, 1, 0, 1, 0};
    vecs[12] = '{3'd6, 1, 1, 1, 0, 0, 1};

    // Four queued fields, alternating targets, pushed on every other cycle.
    do_reset();
    fq = '{3'd0, 3'd2, 3'd0, 3'd5};
    drive();
    idle_c = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (idle_c < 0 && !busy_s) idle_c = cycle;
    end
    check("seqA_push_count", plog.size(), 4);
    for (int k = 0; k < 4 && k < plog.size(); k++) begin
      check("seqA_idx", plog[k].idx, k);
      check("seqA_target", int'(plog[k].raw), k % 2);
      check("seqA_cycle", plog[k].cyc - idle_c, 2 * k + 1);
    end
    check("seqA_outstanding", int'(bus_if.outstanding), 4);
    $display("seqA: %0d pushes, first idle cycle %0d", plog.size(), idle_c);

    // Credit limit: six varints stall after four pushes until one retire.
    do_reset();
    for (int i = 0; i < 6; i++) fq.push_back(3'd0);
    drive();
    repeat (20) step();
    check("seqB_stall_pushes", plog.size(), 4);
    check("seqB_fifo_held", fq.size(), 2);
    bus_if.index_retire = 1'b1;
    step();
    n0 = cycle;
    repeat (6) step();
    check("seqB_push_count", plog.size(), 5);
    if (plog.size() >= 5) begin
      check("seqB_fifth_idx", plog[4].idx, 4);
      check("seqB_fifth_delay", plog[4].cyc - n0, 2);
    end
    $display("seqB: %0d pushes after one retire", plog.size());

    // Classification table: one entry at a time from an idle, empty state.
    do_reset();
    for (int v = 0; v < 13; v++) begin
      n0    = plog.size();
      pops0 = pop_cnt;
      bad0  = exp_bad;
      bus_if.varint_fifo_full   = vecs[v].vfull;
      bus_if.raw_data_fifo_full = vecs[v].rfull;
      fq.push_back(vecs[v].wt);
      drive();
      repeat (4) step();
      nv = 0;
      nr = 0;
      for (int k = n0; k < plog.size(); k++) begin
        if (plog[k].raw) nr++;
        else nv++;
      end
      check("vec_pop", pop_cnt - pops0, vecs[v].exp_pop);
      check("vec_vpush", nv, vecs[v].exp_v);
      check("vec_rpush", nr, vecs[v].exp_r);
      check("vec_bad", int'(bus_if.bad_count), bad0 + vecs[v].exp_bad);
      $display("vec %0d: wt=%0d vfull=%0d rfull=%0d pops=%0d vpush=%0d rpush=%0d",
               v, vecs[v].wt, vecs[v].vfull, vecs[v].rfull, pop_cnt - pops0, nv, nr);
      bus_if.varint_fifo_full   = 1'b0;
      bus_if.raw_data_fifo_full = 1'b0;
      repeat (4) step();
      guard = 0;
      while (exp_out > 0 && guard < 10) begin
        bus_if.index_retire = 1'b1;
        step();
        guard++;
      end
      check("vec_drained", fq.size(), 0);
    end

    // Illegal head is discarded without consuming an index; counter saturates.
    do_reset();
    fq = '{3'd3, 3'd0};
    drive();
    repeat (8) step();
    check("seqC_bad_one", int'(bus_if.bad_count), 1);
    check("seqC_push_count", plog.size(), 1);
    if (plog.size() >= 1) begin
      check("seqC_idx", plog[0].idx, 0);
      check("seqC_target", int'(plog[0].raw), 0);
    end
    for (int i = 0; i < 300; i++) begin
      case (i % 4)
        0: fq.push_back(3'd3);
        1: fq.push_back(3'd4);
        2: fq.push_back(3'd6);
        default: fq.push_back(3'd7);
      endcase
    end
    drive();
    guard = 0;
    while (fq.size() > 0 && guard < 1000) begin
      step();
      guard++;
    end
    step();
    check("seqC_drained", fq.size(), 0);
    check("seqC_bad_sat", int'(bus_if.bad_count), 255);
    $display("seqC: bad_count after 301 illegal entries");

    // Index wrap with a retire after every push.
    do_reset();
    for (int i = 0; i < 1030; i++) begin
      case (i % 3)
        0: fq.push_back(3'd1);
        1: fq.push_back(3'd2);
        default: fq.push_back(3'd5);
      endcase
    end
    drive();
    max_o = 0;
    guard = 0;
    while (plog.size() < 1030 && guard < 4000) begin
      bus_if.index_retire = push_s;
      step();
      guard++;
      if (int'(bus_if.outstanding) > max_o) max_o = int'(bus_if.outstanding);
    end
    check("seqD_push_count", plog.size(), 1030);
    if (plog.size() >= 1025) begin
      check("seqD_idx_1023", plog[1023].idx, 1023);
      check("seqD_idx_wrap", plog[1024].idx, 0);
    end
    check("seqD_max_outstanding", max_o, 1);
    $display("seqD: %0d raw pushes, max outstanding %0d", plog.size(), max_o);

    // Flush with three outstanding: nothing moves until all retire.
    do_reset();
    fq = '{3'd0, 3'd0, 3'd0};
    drive();
    repeat (10) step();
    check("seqE_outstanding", int'(bus_if.outstanding), 3);
    bus_if.flush = 1'b1;
    exp_idx = 0;
    fq.push_back(3'd0);
    fq.push_back(3'd0);
    drive();
    repeat (8) step();
    check("seqE_hold", plog.size(), 3);
    check("seqE_busy", int'(bus_if.busy), 1);
    for (int r = 0; r < 3; r++) begin
      bus_if.index_retire = 1'b1;
      step();
      step();
      if (r == 1) check("seqE_hold_partial", plog.size(), 3);
    end
    guard = 0;
    while (plog.size() < 4 && guard < 12) begin
      step();
      guard++;
    end
    check("seqE_push_after", plog.size(), 4);
    if (plog.size() >= 4) check("seqE_first_idx", plog[3].idx, 0);
    repeat (4) step();
    $display("seqE: flush drained, next index restarted");

    // Flush pulse during INIT is deferred to the first IDLE cycle.
    do_reset();
    bus_if.flush = 1'b1;
    fq = '{3'd0};
    drive();
    idle_c = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (idle_c < 0 && !busy_s) idle_c = cycle;
    end
    check("seqF_push_count", plog.size(), 1);
    if (plog.size() >= 1) check("seqF_delay", plog[0].cyc - idle_c, 4);
    $display("seqF: latched flush, push offset from first idle checked");

    // Retire underflow, then a reset during a varint push cycle.
    do_reset();
    bus_if.index_retire = 1'b1;
    step();
    step();
    check("seqG_underflow", int'(bus_if.underflow_err), 1);
    check("seqG_outstanding", int'(bus_if.outstanding), 0);
    fq = '{3'd0};
    drive();
    reset_on_push = 1'b1;
    guard = 0;
    while (!reset && guard < 10) begin
      step();
      guard++;
    end
    check("seqG_reset_hit", int'(reset), 1);
    check_reset_vals("midreset");
    reset = 1'b0;
    $display("seqG: underflow flagged, mid-push reset returned outputs to reset values");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
